mmio_uart_ctrl: RTL and testbench

//  Memory-mapped I/O controller on the CPU memory stage, decoded beside dmem/imem/bios.

---
 rtl/mmio_uart_ctrl_pkg.sv | 32 +++
 rtl/mmio_rx_fifo.sv | 54 +++++
 rtl/mmio_uart_ctrl.sv | 138 +++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mmio_uart_ctrl_pkg
// Brief   : Register offsets and status bit positions for the MMIO/UART block.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mmio_uart_ctrl_pkg;

  localparam logic [7:0] c_mmio_status = 8'h00;
  localparam logic [7:0] c_mmio_rxdata = 8'h04;
  localparam logic [7:0] c_mmio_txdata = 8'h08;
  localparam logic [7:0] c_mmio_cycle  = 8'h10;
  localparam logic [7:0] c_mmio_instr  = 8'h14;
  localparam logic [7:0] c_mmio_cntrst = 8'h18;

  localparam int c_stat_tx_ready   = 0;
  localparam int c_stat_rx_nonempt = 1;
  localparam int c_stat_rx_overrun = 2;

  function automatic logic [31:0] status_word(input logic tx_ready,
                                               input logic rx_nonempty,
                                               input logic rx_overrun);
    logic [31:0] w;
    w                    = '0;
    w[c_stat_tx_ready]   = tx_ready;
    w[c_stat_rx_nonempt] = rx_nonempty;
    w[c_stat_rx_overrun] = rx_overrun;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mmio_rx_fifo
// Brief   : Small synchronous FIFO with extra-MSB pointers; head is combinational.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mmio_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int           c_aw  = $clog2(DEPTH);
  localparam logic [c_aw:0] c_one = {{c_aw{1'b0}}, 1'b1};

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign head  = r_mem[r_rd_ptr[c_aw-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_one;
    end
  end

  // Storage carries no reset; an entry is only visible once written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mmio_uart_ctrl
// Brief   : MMIO decode for UART TX/RX, cycle/instret counters, registered read data.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [3:0]  mmio_we,
  input  logic        mmio_re,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic        w_hit;
  logic [7:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_load;
  logic        w_tx_hs;
  logic        w_cnt_clr;
  logic        w_push;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_head;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic [31:0] r_cycle;
  logic [31:0] r_instr;
  logic        r_overrun;
  logic [31:0] r_rdata;

  assign w_hit     = (mmio_addr[31:8] == MMIO_BASE[31:8]);
  assign w_off     = mmio_addr[7:0];
  assign w_wr      = w_hit && (mmio_we != 4'b0000);
  assign w_rd      = w_hit && mmio_re;
  assign w_tx_hs   = r_tx_valid && tx_ready;
  assign w_tx_load = w_wr && (w_off == c_mmio_txdata) && !r_tx_valid;
  assign w_cnt_clr = w_wr && (w_off == c_mmio_cntrst);
  assign w_push    = rx_valid && !w_fifo_full;
  assign w_pop     = w_rd && (w_off == c_mmio_rxdata) && !w_fifo_empty;
  assign w_unused  = ^mmio_wdata[31:8];

  mmio_rx_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (rx_data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .head  (w_fifo_head)
  );

  // Read data reflects state before this cycle's updates.
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      c_mmio_status: w_rd_mux = status_word(!r_tx_valid, !w_fifo_empty, r_overrun);
      c_mmio_rxdata: w_rd_mux = w_fifo_empty ? 32'd0 : {24'd0, w_fifo_head};
      c_mmio_cycle:  w_rd_mux = r_cycle;
      c_mmio_instr:  w_rd_mux = r_instr;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_tx_hs) begin
      r_tx_valid <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= mmio_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle <= '0;
      r_instr <= '0;
    end else if (w_cnt_clr) begin
      r_cycle <= '0;
      r_instr <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (inst_retire) r_instr <= r_instr + 32'd1;
    end
  end

  // A fresh overrun wins over a same-cycle STATUS read so no event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (rx_valid && w_fifo_full) begin
      r_overrun <= 1'b1;
    end else if (w_rd && (w_off == c_mmio_status)) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign mmio_rdata = r_rdata;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign rx_ready   = !w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_mmio_uart_ctrl
// Brief   : Directed table-driven bench for mmio_uart_ctrl plus counter/reset sequences.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mmio_uart_ctrl;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] mmio_addr;
  logic [3:0]  mmio_we;
  logic        mmio_re;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        inst_retire;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_uart_ctrl #(
    .MMIO_BASE (B),
    .RX_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mmio_addr   (mmio_addr),
    .mmio_we     (mmio_we),
    .mmio_re     (mmio_re),
    .mmio_wdata  (mmio_wdata),
    .mmio_rdata  (mmio_rdata),
    .inst_retire (inst_retire),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [7:0]  wd;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] exp_rd;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_rxr;
  } vec_t;

  vec_t vecs [36];

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] w, input logic r,
                              input logic [7:0] d, input logic v, input logic [7:0] rd,
                              input logic t, input logic [31:0] e_rd, input logic e_txv,
                              input logic [7:0] e_txd, input logic e_rxr);
    vec_t x;
    x.addr = a; x.we = w; x.re = r; x.wd = d; x.rxv = v; x.rxd = rd; x.txr = t;
    x.exp_rd = e_rd; x.exp_txv = e_txv; x.exp_txd = e_txd; x.exp_rxr = e_rxr;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [3:0] w, input logic r,
                      input logic [31:0] d, input logic v, input logic [7:0] rd,
                      input logic t, input logic ir);
    mmio_addr = a; mmio_we = w; mmio_re = r; mmio_wdata = d;
    rx_valid = v; rx_data = rd; tx_ready = t; inst_retire = ir;
    @(posedge clk);
    #1;
    mmio_we = '0; mmio_re = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; inst_retire = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a);
    step(a, 4'h0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    mmio_addr = '0; mmio_we = '0; mmio_re = 1'b0; mmio_wdata = '0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    //            addr      we    re  wd     rxv rxd    txr  exp_rd  txv txd    rxr
    vecs[0]  = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h00, 1);
    vecs[1]  = mk(B+32'h08, 4'hF, 0, 8'h41, 0, 8'h00, 0, 32'h1,  1, 8'h41, 1);
    vecs[2]  = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h0,  1, 8'h41, 1);
    vecs[3]  = mk(B+32'h08, 4'hF, 0, 8'h99, 0, 8'h00, 0, 32'h0,  1, 8'h41, 1);
    vecs[4]  = mk(B+32'h00, 4'h0, 0, 8'h00, 0, 8'h00, 0, 32'h0,  1, 8'h41, 1);
    vecs[5]  = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 1, 32'h0,  0, 8'h41, 1);
    vecs[6]  = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h41, 1);
    vecs[7]  = mk(B+32'h08, 4'h1, 0, 8'h55, 0, 8'h00, 0, 32'h1,  1, 8'h55, 1);
    vecs[8]  = mk(B+32'h08, 4'hF, 0, 8'h66, 0, 8'h00, 1, 32'h1,  0, 8'h55, 1);
    vecs[9]  = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);
    vecs[10] = mk(B+32'h00, 4'h0, 0, 8'h00, 1, 8'h11, 0, 32'h1,  0, 8'h55, 1);
    vecs[11] = mk(B+32'h00, 4'h0, 0, 8'h00, 1, 8'h22, 0, 32'h1,  0, 8'h55, 1);
    vecs[12] = mk(B+32'h00, 4'h0, 0, 8'h00, 1, 8'h33, 0, 32'h1,  0, 8'h55, 1);
    vecs[13] = mk(B+32'h00, 4'h0, 0, 8'h00, 1, 8'h44, 0, 32'h1,  0, 8'h55, 0);
    vecs[14] = mk(B+32'h00, 4'h0, 0, 8'h00, 1, 8'h55, 0, 32'h1,  0, 8'h55, 0);
    vecs[15] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h7,  0, 8'h55, 0);
    vecs[16] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h3,  0, 8'h55, 0);
    vecs[17] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h11, 0, 8'h55, 1);
    vecs[18] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h22, 0, 8'h55, 1);
    vecs[19] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h33, 0, 8'h55, 1);
    vecs[20] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h44, 0, 8'h55, 1);
    vecs[21] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h0,  0, 8'h55, 1);
    vecs[22] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);
    vecs[23] = mk(B+32'h04, 4'h0, 1, 8'h00, 1, 8'h77, 0, 32'h0,  0, 8'h55, 1);
    vecs[24] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h3,  0, 8'h55, 1);
    vecs[25] = mk(B+32'h04, 4'h0, 1, 8'h00, 1, 8'h88, 0, 32'h77, 0, 8'h55, 1);
    vecs[26] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h88, 0, 8'h55, 1);
    vecs[27] = mk(B+32'h04, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h0,  0, 8'h55, 1);
    vecs[28] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);
    vecs[29] = mk(B+32'h0C, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h0,  0, 8'h55, 1);
    vecs[30] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);
    vecs[31] = mk(B+32'h08, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h0,  0, 8'h55, 1);
    vecs[32] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);
    vecs[33] = mk(32'h7000_0004, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1, 0, 8'h55, 1);
    vecs[34] = mk(32'h0000_0008, 4'hF, 0, 8'hAA, 0, 8'h00, 0, 32'h1, 0, 8'h55, 1);
    vecs[35] = mk(B+32'h00, 4'h0, 1, 8'h00, 0, 8'h00, 0, 32'h1,  0, 8'h55, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset rdata",    mmio_rdata,         32'h0);
    check("reset tx_valid", {31'd0, tx_valid},  32'h0);
    check("reset tx_data",  {24'd0, tx_data},   32'h0);
    check("reset rx_ready", {31'd0, rx_ready},  32'h1);
    rst = 1'b1;

    // Cycle counter after 10 idle edges, then STATUS
    repeat (10) @(posedge clk);
    #1;
    rd_reg(B + 32'h10);
    check("cycle after 10 idle", mmio_rdata, 32'd10);
    rd_reg(B + 32'h00);
    check("status idle", mmio_rdata, 32'h1);

    // Retired-instruction counter
    repeat (3) step(B, 4'h0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    rd_reg(B + 32'h14);
    check("instr after 3 retires", mmio_rdata, 32'd3);

    // Counter clear beats same-cycle retire
    step(B + 32'h18, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd0, 1'b0, 1'b1);
    rd_reg(B + 32'h10);
    check("cycle after clear", mmio_rdata, 32'd0);
    rd_reg(B + 32'h14);
    check("instr after clear+retire", mmio_rdata, 32'd0);
    rd_reg(B + 32'h10);
    check("cycle increments after clear", mmio_rdata, 32'd2);

    // Cycle counter wrap
    force dut.r_cycle = 32'hFFFF_FFFF;
    #2;
    release dut.r_cycle;
    rd_reg(B + 32'h10);
    check("cycle at max", mmio_rdata, 32'hFFFF_FFFF);
    rd_reg(B + 32'h10);
    check("cycle wrapped", mmio_rdata, 32'd0);

    for (int i = 0; i < 36; i++) begin
      step(vecs[i].addr, vecs[i].we, vecs[i].re, {24'd0, vecs[i].wd},
           vecs[i].rxv, vecs[i].rxd, vecs[i].txr, 1'b0);
      check($sformatf("vec%0d rdata", i),    mmio_rdata,          vecs[i].exp_rd);
      check($sformatf("vec%0d tx_valid", i), {31'd0, tx_valid},   {31'd0, vecs[i].exp_txv});
      check($sformatf("vec%0d tx_data", i),  {24'd0, tx_data},    {24'd0, vecs[i].exp_txd});
      check($sformatf("vec%0d rx_ready", i), {31'd0, rx_ready},   {31'd0, vecs[i].exp_rxr});
    end

    // Asynchronous reset mid-TX with a byte queued and nonzero rdata
    step(B + 32'h08, 4'hF, 1'b0, 32'h5A, 1'b0, 8'd0, 1'b0, 1'b0);
    step(B, 4'h0, 1'b0, 32'd0, 1'b1, 8'h12, 1'b0, 1'b0);
    step(B + 32'h04, 4'hF, 1'b0, 32'd0, 1'b1, 8'h34, 1'b0, 1'b1);
    rd_reg(B + 32'h00);
    check("pre-reset status", mmio_rdata, 32'h2);
    check("pre-reset tx_valid", {31'd0, tx_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst tx_valid", {31'd0, tx_valid}, 32'h0);
    check("async rst tx_data",  {24'd0, tx_data},  32'h0);
    check("async rst rdata",    mmio_rdata,        32'h0);
    check("async rst rx_ready", {31'd0, rx_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_reg(B + 32'h00);
    check("post-reset status", mmio_rdata, 32'h1);
    rd_reg(B + 32'h10);
    check("post-reset cycle", mmio_rdata, 32'd1);
    rd_reg(B + 32'h14);
    check("post-reset instr", mmio_rdata, 32'd0);
    rd_reg(B + 32'h04);
    check("post-reset rxdata empty", mmio_rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
